// File: rtl/pipe_ctrl_unit.sv
// Pipeline hazard controller: per-stage bubble tracking, stall/flush to keep/dirty, halt/drain FSM.
// Optional stall/flush perf counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl_unit #(
   parameter int STAGES   = 5,
   parameter int HLT_KEEP = 2,
   parameter int CNT_W    = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_hlt,
   input  logic                              i_resume,
   input  logic [STAGES-1:0]                 i_stall,
   input  logic [STAGES-1:0]                 i_flush,
   output logic [STAGES-1:0]                 o_keep,
   output logic [STAGES-1:0]                 o_dirty,
   output logic                              o_halted,
   output logic [$clog2(STAGES+1)-1:0]       o_occupancy
`ifdef PIPE_PERF_EN
   ,
   input  logic                              i_perf_clr,
   output logic [CNT_W-1:0]                  o_stall_cnt,
   output logic [CNT_W-1:0]                  o_flush_cnt
`endif
);

   localparam int OCC_W = $clog2(STAGES+1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [STAGES-1:0]   r_bubble;
   logic [STAGES-1:0]   w_bubble_nxt;
   logic [STAGES-1:0]   w_stall_pre;
   logic [STAGES-1:0]   w_flush_pre;
   logic [STAGES-1:0]   w_bub_flushed;
   logic [STAGES:0]     w_stall_ext;
   logic [STAGES:0]     w_shift_src;
   logic                w_fetch_bub;
   logic [OCC_W-1:0]    w_occ;

   // Prefix ORs: bit k is set when any request exists at or below stage k.
   always_comb begin
      w_stall_pre[0] = i_stall[0];
      w_flush_pre[0] = i_flush[0];
      for (int k = 1; k < STAGES; k++) begin
         w_stall_pre[k] = w_stall_pre[k-1] | i_stall[k];
         w_flush_pre[k] = w_flush_pre[k-1] | i_flush[k];
      end
   end

   assign w_fetch_bub   = (r_state != ST_RUN);
   assign w_bub_flushed = r_bubble | w_flush_pre;
   assign w_stall_ext   = {1'b0, w_stall_pre};
   assign w_shift_src   = {w_fetch_bub, w_bub_flushed};

   // Held stages keep their bit, the stage just below the lowest stall gets a bubble, older stages shift.
   always_comb begin
      w_bubble_nxt = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (w_stall_pre[k])
            w_bubble_nxt[k] = w_bub_flushed[k];
         else if (w_stall_ext[k+1])
            w_bubble_nxt[k] = 1'b1;
         else
            w_bubble_nxt[k] = w_shift_src[k+1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_bubble <= '1;
      else
         r_bubble <= w_bubble_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (i_hlt)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!i_hlt)
               w_state_nxt = ST_RUN;
            else if (&w_bubble_nxt[STAGES-HLT_KEEP-1:0])
               w_state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            if (i_resume && !i_hlt)
               w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Outside RUN the youngest HLT_KEEP stages are frozen on top of any stall hold.
   always_comb begin
      o_halted = (r_state == ST_HALTED);
      o_keep   = w_stall_pre;
      for (int k = 0; k < STAGES; k++) begin
         if ((r_state != ST_RUN) && (k >= STAGES-HLT_KEEP))
            o_keep[k] = 1'b1;
      end
   end

   assign o_dirty = r_bubble | w_flush_pre | w_stall_pre;

   always_comb begin
      w_occ = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (!r_bubble[k])
            w_occ = w_occ + OCC_W'(1);
      end
   end

   assign o_occupancy = w_occ;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating counters; clear takes priority over a same-cycle increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_perf_clr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((|i_stall) && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((|i_flush) && !(&r_flush_cnt))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit (STAGES=5, HLT_KEEP=2): directed steps plus random traffic against a reference model.
module tb_pipe_ctrl_unit;
   localparam int S  = 5;
   localparam int HK = 2;
   localparam int OW = $clog2(S+1);
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, hlt, resume;
   logic [S-1:0]  stall, flush, keep, dirty;
   logic          halted;
   logic [OW-1:0] occ;
`ifdef PIPE_PERF_EN
   logic          perf_clr;
   logic [CW-1:0] stall_cnt, flush_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: mode 0 = running, 1 = draining, 2 = halted.
   bit m_bub[S];
   int m_mode;
   int m_sc, m_fc;

   pipe_ctrl_unit #(.STAGES(S), .HLT_KEEP(HK), .CNT_W(CW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_hlt       (hlt),
      .i_resume    (resume),
      .i_stall     (stall),
      .i_flush     (flush),
      .o_keep      (keep),
      .o_dirty     (dirty),
      .o_halted    (halted),
      .o_occupancy (occ)
`ifdef PIPE_PERF_EN
      ,
      .i_perf_clr  (perf_clr),
      .o_stall_cnt (stall_cnt),
      .o_flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [S-1:0] v);
      for (int i = 0; i < S; i++)
         if (v[i]) return i;
      return S;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < S; i++) m_bub[i] = 1'b1;
      m_mode = 0;
      m_sc   = 0;
      m_fc   = 0;
   endtask

   task automatic check_all(input string tag);
      int f, s, eo;
      logic [S-1:0] ek, ed;
      f  = lowest(flush);
      s  = lowest(stall);
      eo = 0;
      for (int k = 0; k < S; k++) begin
         ed[k] = m_bub[k] || (k >= f) || (k >= s);
         ek[k] = (k >= s) || (m_mode != 0 && k >= S-HK);
         if (!m_bub[k]) eo++;
      end
      chk({tag, ".keep"},   keep,   ek);
      chk({tag, ".dirty"},  dirty,  ed);
      chk({tag, ".occ"},    occ,    eo);
      chk({tag, ".halted"}, halted, m_mode == 2);
`ifdef PIPE_PERF_EN
      chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
      chk({tag, ".flush_cnt"}, flush_cnt, m_fc);
`endif
   endtask

   // Advance model and DUT by one clock edge using the inputs currently applied.
   task automatic tick();
      int f, s, nm;
      bit b[S];
      bit n[S];
      bit all_empty;
      f = lowest(flush);
      s = lowest(stall);
      b = m_bub;
      for (int i = f; i < S; i++) b[i] = 1'b1;
      if (s == S) begin
         for (int i = 0; i < S-1; i++) n[i] = b[i+1];
         n[S-1] = (m_mode != 0);
      end else begin
         for (int i = 0; i < S; i++) begin
            if (i >= s)          n[i] = b[i];
            else if (i == s-1)   n[i] = 1'b1;
            else                 n[i] = b[i+1];
         end
      end
      nm = m_mode;
      if (m_mode == 0) begin
         if (hlt) nm = 1;
      end else if (m_mode == 1) begin
         all_empty = 1'b1;
         for (int i = 0; i < S-HK; i++) if (!n[i]) all_empty = 1'b0;
         if (!hlt) nm = 0;
         else if (all_empty) nm = 2;
      end else begin
         if (resume && !hlt) nm = 0;
      end
      @(posedge clk);
      m_bub  = n;
      m_mode = nm;
`ifdef PIPE_PERF_EN
      if (perf_clr) begin
         m_sc = 0;
         m_fc = 0;
      end else begin
         if (stall != 0 && m_sc < (1 << CW) - 1) m_sc++;
         if (flush != 0 && m_fc < (1 << CW) - 1) m_fc++;
      end
`endif
      @(negedge clk);
   endtask

   task automatic cyc(input string tag);
      #1;
      check_all(tag);
      tick();
   endtask

   task automatic idle(input int n);
      stall = '0; flush = '0; resume = 1'b0;
      for (int i = 0; i < n; i++) cyc("idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [S-1:0] drain_seq [5];
      drain_seq = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
      rst = 1'b1; hlt = 1'b0; resume = 1'b0; stall = '0; flush = '0;
`ifdef PIPE_PERF_EN
      perf_clr = 1'b0;
`endif
      model_reset();
      @(negedge clk);

      // Reset and refill
      do_reset();
      chk("rst_dirty", dirty, 5'b11111);
      chk("rst_occ", occ, 0);
      chk("rst_halted", halted, 0);
      idle(5);
      #1;
      chk("fill_occ", occ, 5);
      chk("fill_dirty", dirty, 5'b00000);

      // Single stall in a full pipe
      stall = 5'b00100;
      #1;
      chk("stall_keep", keep, 5'b11100);
      chk("stall_dirty", dirty, 5'b11100);
      cyc("stall");
      stall = '0;
      #1;
      chk("stall_next", dirty, 5'b00010);
      idle(5);

      // Flush, then flush combined with a younger stall
      flush = 5'b01000;
      #1;
      chk("flush_dirty", dirty, 5'b11000);
      cyc("flush");
      flush = '0;
      #1;
      chk("flush_next", dirty, 5'b01100);
      idle(5);
      flush = 5'b00010; stall = 5'b01000;
      #1;
      chk("fs_keep", keep, 5'b11000);
      cyc("flush_stall");
      flush = '0; stall = '0;
      #1;
      chk("fs_next", dirty, 5'b11111);
      idle(5);

      // Halt drain from a full pipe
      hlt = 1'b1;
      cyc("halt_e1");
      #1;
      chk("drain_keep", keep, 5'b11000);
      chk("drain_e1_dirty", dirty, 5'b00000);
      for (int t = 0; t < 5; t++) begin
         cyc("drain");
         chk("drain_dirty", dirty, drain_seq[t]);
         chk("drain_halted", halted, (t == 4) ? 1'b1 : 1'b0);
      end
      chk("halt_occ", occ, 0);

      // hlt wins over resume, then resume
      resume = 1'b1;
      cyc("hlt_wins");
      chk("hlt_wins_halted", halted, 1);
      hlt = 1'b0;
      cyc("resume");
      resume = 1'b0;
      #1;
      chk("resume_halted", halted, 0);
      chk("resume_keep", keep, 5'b00000);
      cyc("post_resume");
      #1;
      chk("resume_bubble", dirty, 5'b01111);
      idle(5);

      // Drain cancelled by dropping hlt
      hlt = 1'b1;
      cyc("cancel_e1");
      #1;
      chk("cancel_drain_keep", keep, 5'b11000);
      hlt = 1'b0;
      cyc("cancel_e2");
      #1;
      chk("cancel_run_keep", keep, 5'b00000);
      chk("cancel_halted", halted, 0);
      idle(5);

      // Reset in the middle of a drain
      hlt = 1'b1;
      cyc("mid_e1");
      cyc("mid_e2");
      do_reset();
      chk("midrst_dirty", dirty, 5'b11111);
      chk("midrst_keep", keep, 5'b00000);
      hlt = 1'b0;

`ifdef PIPE_PERF_EN
      stall = 5'b00001;
      for (int i = 0; i < 3; i++) cyc("perf_stall");
      stall = '0; flush = 5'b00001;
      cyc("perf_flush");
      flush = '0;
      #1;
      chk("perf_stall_cnt", stall_cnt, 3);
      chk("perf_flush_cnt", flush_cnt, 1);
      perf_clr = 1'b1;
      stall = 5'b00010;
      cyc("perf_clr");
      perf_clr = 1'b0; stall = '0;
      #1;
      chk("perf_clr_stall", stall_cnt, 0);
      chk("perf_clr_flush", flush_cnt, 0);
`endif
      idle(5);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         stall  = ($urandom_range(0, 3) == 0) ? S'($urandom) & S'($urandom) : '0;
         flush  = ($urandom_range(0, 4) == 0) ? S'($urandom) & S'($urandom) : '0;
         resume = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) hlt = ~hlt;
`ifdef PIPE_PERF_EN
         perf_clr = ($urandom_range(0, 40) == 0);
`endif
         if ($urandom_range(0, 150) == 0) do_reset();
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
